// File: rtl/seq_counter_pkg.sv
// Shared mode encodings and per-mode seed values for the sequence counter.
package seq_counter_pkg;

   localparam int MAX_W = 16;

   localparam logic [2:0] MODE_BIN_UP   = 3'd0;
   localparam logic [2:0] MODE_BIN_DOWN = 3'd1;
   localparam logic [2:0] MODE_GRAY     = 3'd2;
   localparam logic [2:0] MODE_RING     = 3'd3;
   localparam logic [2:0] MODE_JOHNSON  = 3'd4;
   localparam logic [2:0] MODE_LFSR     = 3'd5;

   // Seed is 1 for the one-hot and LFSR sequences (0 would lock them up), 0 otherwise.
   function automatic logic [MAX_W-1:0] seed(input logic [2:0] mode, input int width);
      logic [MAX_W:0]   lim;
      logic [MAX_W-1:0] base;
      lim  = (MAX_W+1)'(1) << width;
      base = (mode == MODE_RING || mode == MODE_LFSR) ? MAX_W'(1) : '0;
      return base & MAX_W'(lim - (MAX_W+1)'(1));
   endfunction

endpackage

// File: rtl/seq_next_state.sv
// Combinational successor and terminal-count decode for every counter mode.
module seq_next_state
   import seq_counter_pkg::*;
#(
   parameter int               WIDTH   = 4,
   parameter int               MODULUS = 16,
   parameter logic [WIDTH-1:0] TAPS    = WIDTH'(4'b1001)
) (
   input  logic [WIDTH-1:0] s,
   input  logic [2:0]       mode,
   output logic [WIDTH-1:0] nxt,
   output logic             tc
);

   // MODULUS-1 is formed in integer arithmetic so MODULUS=2^WIDTH does not overflow.
   localparam logic [WIDTH-1:0] MOD_M1  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] MSB_ONE = ONE << (WIDTH - 1);

   logic             fb;
   logic [WIDTH-1:0] lfsr_nxt;

   always_comb begin
      fb       = ^(s & TAPS);
      lfsr_nxt = {s[WIDTH-2:0], fb};
      nxt      = s;
      tc       = 1'b0;
      case (mode)
         MODE_BIN_UP, MODE_GRAY: begin
            nxt = (s == MOD_M1) ? '0 : s + ONE;
            tc  = (s == MOD_M1);
         end
         MODE_BIN_DOWN: begin
            nxt = (s == '0) ? MOD_M1 : s - ONE;
            tc  = (s == '0);
         end
         MODE_RING: begin
            nxt = {s[WIDTH-2:0], s[WIDTH-1]};
            tc  = (s == MSB_ONE);
         end
         MODE_JOHNSON: begin
            nxt = {s[WIDTH-2:0], ~s[WIDTH-1]};
            tc  = (s == MSB_ONE);
         end
         MODE_LFSR: begin
            nxt = lfsr_nxt;
            tc  = (lfsr_nxt == ONE);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/seq_counter_gen.sv
// Multi-mode sequence counter: state/mode registers, edge priority, load
// correction and Gray output mapping around the seq_next_state decoder.
module seq_counter_gen
   import seq_counter_pkg::*;
#(
   parameter int               WIDTH   = 4,
   parameter int               MODULUS = 16,
   parameter logic [WIDTH-1:0] TAPS    = WIDTH'(4'b1001)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] D,
   input  logic [2:0]       MODE,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             WRAP
);

   localparam logic [WIDTH-1:0] MOD_M1 = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

   logic [WIDTH-1:0] s_q, s_d;
   logic [2:0]       mode_q, mode_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] seed_val;
   logic [WIDTH-1:0] load_val;

   seq_next_state #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS),
      .TAPS    (TAPS)
   ) u_next (
      .s    (s_q),
      .mode (mode_q),
      .nxt  (nxt),
      .tc   (TC)
   );

   // Reserved modes keep whatever state is already present.
   always_comb begin
      seed_val = (MODE > MODE_LFSR) ? s_q : WIDTH'(seed(MODE, WIDTH));
   end

   always_comb begin
      load_val = D;
      case (mode_q)
         MODE_BIN_UP, MODE_BIN_DOWN, MODE_GRAY: load_val = (D > MOD_M1) ? '0 : D;
         MODE_RING, MODE_LFSR:                  load_val = (D == '0) ? ONE : D;
         default: ;
      endcase
   end

   always_comb begin
      s_d    = s_q;
      mode_d = mode_q;
      wrap_d = 1'b0;
      if (MODE != mode_q) begin
         mode_d = MODE;
         s_d    = seed_val;
      end else if (LOAD) begin
         s_d = load_val;
      end else if (EN) begin
         s_d    = nxt;
         wrap_d = TC;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         mode_q <= MODE;
         s_q    <= seed_val;
         wrap_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
         s_q    <= s_d;
         wrap_q <= wrap_d;
      end
   end

   always_comb begin
      Q = (mode_q == MODE_GRAY) ? (s_q ^ (s_q >> 1)) : s_q;
   end

   assign WRAP = wrap_q;

endmodule
